// File: rtl/stream_accumulator_pkg.sv
// Shared definitions for stream_accumulator.
//   - state_e        : FSM state encoding (IDLE / ACCUM / OUTPUT)
//   - OP_ADD, OP_SUB : operation tag values carried on in_op
//   - signed_max/min : two's-complement extremes for a given width,
//                      returned in a 64-bit container (caller truncates)
// Optional build macro: STREAM_ACCUMULATOR_SATURATE_EN (used by the datapath core).

package stream_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // +(2^(w-1) - 1), zero-extended to 64 bits
    function automatic logic [63:0] signed_max(input int unsigned w);
        logic [63:0] m;
        m = (64'd1 << (w - 1)) - 64'd1;
        return m;
    endfunction

    // -2^(w-1); only the low w bits are meaningful (1 followed by zeros)
    function automatic logic [63:0] signed_min(input int unsigned w);
        logic [63:0] m;
        m = 64'd1 << (w - 1);
        return m;
    endfunction

endpackage

// File: rtl/accum_addsub_core.sv
// Combinational signed add/subtract with overflow detection.
//   a   : accumulator operand (WIDTH)
//   b   : incoming operand (WIDTH)
//   op  : OP_ADD -> r = a + b, OP_SUB -> r = a - b
//   r   : result, modulo 2^WIDTH (clamped on overflow when saturating)
//   ovf : signed overflow of the true result
// Build macro STREAM_ACCUMULATOR_SATURATE_EN: when defined, an overflowing result
// is clamped to the signed extreme matching the sign of a.

module accum_addsub_core
    import stream_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] r,
    output logic             ovf
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    always_comb begin
        // Subtraction as a + ~b + 1; overflow is judged against the original b.
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = a + b_eff + {{(WIDTH-1){1'b0}}, op};
        if (op == OP_SUB) begin
            ovf = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
        end else begin
            ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        end
    end

`ifdef STREAM_ACCUMULATOR_SATURATE_EN
    logic [63:0] max_full;
    logic [63:0] min_full;

    always_comb begin
        max_full = signed_max(WIDTH);
        min_full = signed_min(WIDTH);
        r        = sum;
        // On overflow the true result always carries the sign of a.
        if (ovf) begin
            r = a[MSB] ? min_full[WIDTH-1:0] : max_full[WIDTH-1:0];
        end
    end
`else
    assign r = sum;
`endif

endmodule

// File: rtl/stream_accumulator.sv
// Signed stream accumulator with valid/ready handshakes.
// Folds a packet of add/sub-tagged operands into a running sum and presents one
// result per packet (closed by in_last) with a sticky overflow flag.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_op/in_last : operand beat stream
//   out_valid/out_ready/out_data/out_overflow : result stream
//   busy                            : packet in progress (state != IDLE)
// Build macro STREAM_ACCUMULATOR_SATURATE_EN selects saturating arithmetic in
// accum_addsub_core; default is wrap-around.

module stream_accumulator
    import stream_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_r;
    logic             core_ovf;
    logic             xfer;

    assign in_ready  = (state_q != OUTPUT);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign xfer      = in_valid && in_ready;

    // First beat of a packet always starts from zero.
    assign core_a = (state_q == IDLE) ? '0 : acc_q;

    accum_addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (core_a),
        .b   (in_data),
        .op  (in_op),
        .r   (core_r),
        .ovf (core_ovf)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sticky_d   = sticky_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    acc_d    = core_r;
                    sticky_d = core_ovf;
                    if (in_last) begin
                        state_d    = OUTPUT;
                        out_data_d = core_r;
                        out_ovf_d  = core_ovf;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (xfer) begin
                    acc_d    = core_r;
                    sticky_d = sticky_q | core_ovf;
                    if (in_last) begin
                        state_d    = OUTPUT;
                        out_data_d = core_r;
                        out_ovf_d  = sticky_q | core_ovf;
                    end
                end
            end
            OUTPUT: begin
                // Result registers hold until the handshake; only the
                // accumulation state is cleared for the next packet.
                if (out_ready) begin
                    state_d  = IDLE;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                acc_d    = '0;
                sticky_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sticky_q   <= sticky_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_stream_accumulator.sv
module tb_stream_accumulator;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_op;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_overflow;
    logic             busy;

    int checks = 0;
    int errors = 0;

    stream_accumulator #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_op        (in_op),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       op;
        logic       last;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took the beat.
    task automatic send_beat(input logic [7:0] d, input logic op, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // {data, op, last, expected out_data, expected out_overflow}
        vecs.push_back('{8'd5,   1'b0, 1'b1, 8'h05, 1'b0});
        vecs.push_back('{8'd5,   1'b1, 1'b1, 8'hFB, 1'b0});
        vecs.push_back('{8'd10,  1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd20,  1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd5,   1'b1, 1'b1, 8'h19, 1'b0});
        vecs.push_back('{8'hFD,  1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hFC,  1'b1, 1'b1, 8'h01, 1'b0});
`ifdef STREAM_ACCUMULATOR_SATURATE_EN
        vecs.push_back('{8'd100, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd50,  1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd30,  1'b1, 1'b1, 8'h61, 1'b1});
        vecs.push_back('{8'd100, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd100, 1'b0, 1'b1, 8'h7F, 1'b1});
        vecs.push_back('{8'h80,  1'b1, 1'b1, 8'h7F, 1'b1});
        vecs.push_back('{8'h80,  1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd1,   1'b1, 1'b1, 8'h80, 1'b1});
        vecs.push_back('{8'd100, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd100, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd100, 1'b0, 1'b1, 8'h7F, 1'b1});
`else
        vecs.push_back('{8'd100, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd50,  1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd30,  1'b1, 1'b1, 8'h78, 1'b1});
        vecs.push_back('{8'd100, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd100, 1'b0, 1'b1, 8'hC8, 1'b1});
        vecs.push_back('{8'h80,  1'b1, 1'b1, 8'h80, 1'b1});
        vecs.push_back('{8'h80,  1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd1,   1'b1, 1'b1, 8'h7F, 1'b1});
        vecs.push_back('{8'd100, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd100, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'd100, 1'b0, 1'b1, 8'h2C, 1'b1});
`endif
        // Sticky must be clear again for the packet after an overflow.
        vecs.push_back('{8'd1,   1'b0, 1'b1, 8'h01, 1'b0});

        #12;
        check("rst_in_ready",  64'(in_ready),     64'd1);
        check("rst_out_valid", 64'(out_valid),    64'd0);
        check("rst_out_data",  64'(out_data),     64'd0);
        check("rst_out_ovf",   64'(out_overflow), 64'd0);
        check("rst_busy",      64'(busy),         64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;  // held high ahead of any result
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            send_beat(vecs[i].data, vecs[i].op, vecs[i].last);
            if (vecs[i].last) begin
                check($sformatf("vec%0d_out_valid", i), 64'(out_valid),    64'd1);
                check($sformatf("vec%0d_out_data", i),  64'(out_data),     64'(vecs[i].exp_data));
                check($sformatf("vec%0d_out_ovf", i),   64'(out_overflow), 64'(vecs[i].exp_ovf));
                check($sformatf("vec%0d_in_ready", i),  64'(in_ready),     64'd0);
                @(posedge clk);
                #1;
                check($sformatf("vec%0d_out_done", i),  64'(out_valid),    64'd0);
            end else begin
                check($sformatf("vec%0d_busy", i),      64'(busy),         64'd1);
                check($sformatf("vec%0d_no_out", i),    64'(out_valid),    64'd0);
            end
        end

        // Stall mid-packet: acc must hold across idle input cycles.
        send_beat(8'd4, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("stall_busy", 64'(busy), 64'd1);
        send_beat(8'd6, 1'b0, 1'b1);
        check("stall_out_data", 64'(out_data), 64'h0A);
        @(posedge clk);
        #1;

        // Backpressure on an overflowing packet, with the next beat waiting.
        out_ready = 1'b0;
        send_beat(8'd100, 1'b0, 1'b0);
        send_beat(8'd100, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'd9;
        in_op    = 1'b0;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d_in_ready", k),  64'(in_ready),  64'd0);
`ifdef STREAM_ACCUMULATOR_SATURATE_EN
            check($sformatf("bp%0d_out_data", k),  64'(out_data),  64'h7F);
`else
            check($sformatf("bp%0d_out_data", k),  64'(out_data),  64'hC8);
`endif
            check($sformatf("bp%0d_out_ovf", k),   64'(out_overflow), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released_valid", 64'(out_valid), 64'd0);
        check("bp_released_ready", 64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_next_valid", 64'(out_valid),    64'd1);
        check("bp_next_data",  64'(out_data),     64'h09);
        check("bp_next_ovf",   64'(out_overflow), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a packet.
        send_beat(8'd10, 1'b0, 1'b0);
        send_beat(8'd20, 1'b0, 1'b0);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid),    64'd0);
        check("mid_rst_out_data",  64'(out_data),     64'd0);
        check("mid_rst_out_ovf",   64'(out_overflow), 64'd0);
        check("mid_rst_busy",      64'(busy),         64'd0);
        check("mid_rst_in_ready",  64'(in_ready),     64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(8'd7, 1'b0, 1'b1);
        check("post_rst_valid", 64'(out_valid),    64'd1);
        check("post_rst_data",  64'(out_data),     64'h07);
        check("post_rst_ovf",   64'(out_overflow), 64'd0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
